// File: rtl/play_arbiter_if.sv
// -----------------------------------------------------------------------------
// play_arbiter_if
//   Bundles the play_arbiter source and output signals.
//   slave  : the arbiter itself (sees the three sources, drives the outputs)
//   master : the surrounding logic (drives the sources, reads the outputs)
//
//   mode_in[2:0]                 raw mode switches: 100 free, 010 auto,
//                                001 learn, anything else = none
//   free_keys/free_note/free_octave            free-play source (7/4/2)
//   auto_note/auto_led/auto_octave/auto_num    auto player source (4/7/2/4)
//   learn_note/learn_led/learn_octave/learn_num learn player source (4/7/2/4)
//   note_out/led_out/octave_out/num            shared output path (4/7/2/4)
//   player_rst                   reset to the auto and learn players
//   mode_active[2:0]             one-hot granted source, 000 when none
//   busy                         high while settling or muting
// -----------------------------------------------------------------------------
interface play_arbiter_if;
  logic [2:0] mode_in;
  logic [6:0] free_keys;
  logic [3:0] free_note;
  logic [1:0] free_octave;
  logic [3:0] auto_note;
  logic [6:0] auto_led;
  logic [1:0] auto_octave;
  logic [3:0] auto_num;
  logic [3:0] learn_note;
  logic [6:0] learn_led;
  logic [1:0] learn_octave;
  logic [3:0] learn_num;
  logic [3:0] note_out;
  logic [6:0] led_out;
  logic [1:0] octave_out;
  logic [3:0] num;
  logic       player_rst;
  logic [2:0] mode_active;
  logic       busy;

  modport slave (
    input  mode_in, free_keys, free_note, free_octave,
           auto_note, auto_led, auto_octave, auto_num,
           learn_note, learn_led, learn_octave, learn_num,
    output note_out, led_out, octave_out, num, player_rst, mode_active, busy
  );

  modport master (
    output mode_in, free_keys, free_note, free_octave,
           auto_note, auto_led, auto_octave, auto_num,
           learn_note, learn_led, learn_octave, learn_num,
    input  note_out, led_out, octave_out, num, player_rst, mode_active, busy
  );
endinterface

// File: rtl/play_arbiter.sv
// -----------------------------------------------------------------------------
// play_arbiter
//   Shares the single note/LED/octave/number path between free play, the auto
//   player and the learn player. The mode switch is synchronised and
//   debounced; every accepted handover passes through a silent gap during
//   which the players are held in reset, so the incoming mode starts clean.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    play_arbiter_if.slave (sources in, shared outputs out)
//
//   Parameters:
//     DEB_CYCLES  cycles the synchronised mode must be stable to be accepted
//     GAP_CYCLES  cycles of forced silence plus player reset per handover
//     CNT_W       width of the shared debounce/gap counter
//
//   Optional feature macro: ARB_KEY_OVERRIDE_EN
//     When defined, pressing any free-play key while the auto player is
//     granted temporarily shows the free-play note/keys/octave (the song
//     number stays the auto player's). Undefined: keys only matter in free
//     mode.
// -----------------------------------------------------------------------------
module play_arbiter #(
  parameter int DEB_CYCLES = 1000,
  parameter int GAP_CYCLES = 500,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  play_arbiter_if.slave bus
);

  localparam logic [2:0] M_NONE  = 3'b000;
  localparam logic [2:0] M_FREE  = 3'b100;
  localparam logic [2:0] M_AUTO  = 3'b010;
  localparam logic [2:0] M_LEARN = 3'b001;

  localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] GAP_T = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    MUTE   = 2'd2,
    GRANT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       active_q, active_d;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       ms;

  logic [3:0] note_q, note_d;
  logic [6:0] led_q, led_d;
  logic [1:0] octave_q, octave_d;
  logic [3:0] num_q, num_d;
  logic       busy_q, busy_d;

  // Two-stage synchroniser for the asynchronous mode switches.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.mode_in;
      sync2_q <= sync1_q;
    end
  end

  // Only the three one-hot codes select a source; everything else means none.
  always_comb begin
    ms = M_NONE;
    if (sync2_q == M_FREE || sync2_q == M_AUTO || sync2_q == M_LEARN) begin
      ms = sync2_q;
    end
  end

  // Next-state logic. The counter starts at 1 on entry to SETTLE/MUTE and is
  // only incremented below its terminal value, so it can never wrap.
  // NOTE: every signal written in this block gets a default first, otherwise
  // paths that do not assign it would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        if (ms != M_NONE) begin
          cand_d  = ms;
          cnt_d   = ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (ms == active_q) begin
          // Mode bounced back to the current owner: abandon the switch.
          state_d = (active_q == M_NONE) ? IDLE : GRANT;
        end else if (ms != cand_q) begin
          cand_d = ms;
          cnt_d  = ONE;
        end else if (cnt_q == DEB_T) begin
          state_d  = MUTE;
          cnt_d    = ONE;
          active_d = M_NONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      MUTE: begin
        // Switch input is deliberately ignored here; a change is picked up
        // by a fresh SETTLE once GRANT/IDLE is reached.
        if (cnt_q == GAP_T) begin
          active_d = cand_q;
          state_d  = (cand_q == M_NONE) ? IDLE : GRANT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      GRANT: begin
        if (ms != active_q) begin
          cand_d  = ms;
          cnt_d   = ONE;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output data follows the source that will own the path next cycle, so the
  // new source appears in the same cycle the grant is registered.
  always_comb begin
    note_d   = '0;
    led_d    = '0;
    octave_d = '0;
    num_d    = '0;
    if (state_d == GRANT || state_d == SETTLE) begin
      unique case (active_d)
        M_FREE: begin
          note_d   = bus.free_note;
          led_d    = bus.free_keys;
          octave_d = bus.free_octave;
        end
        M_AUTO: begin
          note_d   = bus.auto_note;
          led_d    = bus.auto_led;
          octave_d = bus.auto_octave;
          num_d    = bus.auto_num;
        end
        M_LEARN: begin
          note_d   = bus.learn_note;
          led_d    = bus.learn_led;
          octave_d = bus.learn_octave;
          num_d    = bus.learn_num;
        end
        default: ;
      endcase
    end
`ifdef ARB_KEY_OVERRIDE_EN
    // A pressed key takes over the sound from the auto player without
    // resetting it; the song number keeps showing the auto song.
    if (state_q == GRANT && active_q == M_AUTO && bus.free_keys != '0) begin
      note_d   = bus.free_note;
      led_d    = bus.free_keys;
      octave_d = bus.free_octave;
    end
`endif
    busy_d = (state_d == SETTLE) || (state_d == MUTE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= M_NONE;
      active_q <= M_NONE;
      note_q   <= '0;
      led_q    <= '0;
      octave_q <= '0;
      num_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      active_q <= active_d;
      note_q   <= note_d;
      led_q    <= led_d;
      octave_q <= octave_d;
      num_q    <= num_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.note_out    = note_q;
  assign bus.led_out     = led_q;
  assign bus.octave_out  = octave_q;
  assign bus.num         = num_q;
  assign bus.mode_active = active_q;
  assign bus.busy        = busy_q;
  // Combinational so the players are reset in the same cycle as the arbiter.
  assign bus.player_rst  = reset | (state_q == MUTE);

endmodule

// File: tb/tb_play_arbiter.sv
// -----------------------------------------------------------------------------
// tb_play_arbiter
//   Self-checking bench for play_arbiter with DEB_CYCLES=4, GAP_CYCLES=3, so a
//   mode edge reaches the outputs 2+4+3+1 = 10 cycles later. Inputs are
//   driven and outputs sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_play_arbiter;

  localparam logic [2:0] M_NONE  = 3'b000;
  localparam logic [2:0] M_FREE  = 3'b100;
  localparam logic [2:0] M_AUTO  = 3'b010;
  localparam logic [2:0] M_LEARN = 3'b001;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  play_arbiter_if bus ();

  play_arbiter #(
    .DEB_CYCLES(4),
    .GAP_CYCLES(3),
    .CNT_W     (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] mode;
    logic [3:0] fn; logic [6:0] fk; logic [1:0] fo;
    logic [3:0] an; logic [6:0] al; logic [1:0] ao; logic [3:0] anum;
    logic [3:0] ln; logic [6:0] ll; logic [1:0] lo; logic [3:0] lnum;
    logic [3:0] e_note; logic [6:0] e_led; logic [1:0] e_oct; logic [3:0] e_num;
    logic [2:0] e_act;
  } vec_t;

  vec_t       vecs [7];
  logic [2:0] cur_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic switch_to(input logic [2:0] m);
    bus.mode_in = m;
    repeat (10) tick();
    cur_mode = m;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] n, input logic [6:0] l,
                               input logic [1:0] o, input logic [3:0] s, input logic [2:0] a);
    check({tag, " note"},   32'(bus.note_out),    32'(n));
    check({tag, " led"},    32'(bus.led_out),     32'(l));
    check({tag, " octave"}, 32'(bus.octave_out),  32'(o));
    check({tag, " num"},    32'(bus.num),         32'(s));
    check({tag, " active"}, 32'(bus.mode_active), 32'(a));
  endtask

  // Switch from the current grant to "none" via the given code.
  task automatic none_check(input string tag, input logic [2:0] code);
    bus.mode_in = code;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 8) check({tag, " rst in gap"}, 32'(bus.player_rst), 32'd1);
    end
    check_outputs(tag, 4'd0, 7'd0, 2'd0, 4'd0, M_NONE);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " rst"},  32'(bus.player_rst), 32'd0);
    repeat (2) tick();
    check({tag, " idle stays"}, 32'(bus.mode_active), 32'(M_NONE));
    check({tag, " idle note"},  32'(bus.note_out), 32'd0);
    cur_mode = M_NONE;
  endtask

  initial begin
    int rst_cnt;
    int busy_cnt;
    n_pass  = 0;
    n_total = 0;
    cur_mode = M_NONE;

    vecs[0] = '{M_AUTO,  4'd1, 7'h00, 2'd1, 4'd9, 7'h55, 2'd2, 4'd4,  4'hC, 7'h2A, 2'd3, 4'd7,
                4'd9,  7'h55, 2'd2, 4'd4,  M_AUTO};
    vecs[1] = '{M_AUTO,  4'd1, 7'h00, 2'd1, 4'd4, 7'h01, 2'd0, 4'd15, 4'hC, 7'h2A, 2'd3, 4'd7,
                4'd4,  7'h01, 2'd0, 4'd15, M_AUTO};
    vecs[2] = '{M_FREE,  4'd5, 7'h10, 2'd3, 4'd4, 7'h01, 2'd0, 4'd15, 4'hC, 7'h2A, 2'd3, 4'd7,
                4'd5,  7'h10, 2'd3, 4'd0,  M_FREE};
    vecs[3] = '{M_FREE,  4'd0, 7'h00, 2'd1, 4'd4, 7'h01, 2'd0, 4'd15, 4'hC, 7'h2A, 2'd3, 4'd7,
                4'd0,  7'h00, 2'd1, 4'd0,  M_FREE};
    vecs[4] = '{M_FREE,  4'd12, 7'h7F, 2'd2, 4'd9, 7'h22, 2'd1, 4'd9, 4'hC, 7'h2A, 2'd3, 4'd7,
                4'd12, 7'h7F, 2'd2, 4'd0,  M_FREE};
    vecs[5] = '{M_LEARN, 4'd12, 7'h7F, 2'd2, 4'd9, 7'h22, 2'd1, 4'd9, 4'd6, 7'h03, 2'd1, 4'd8,
                4'd6,  7'h03, 2'd1, 4'd8,  M_LEARN};
    vecs[6] = '{M_LEARN, 4'd3, 7'h08, 2'd0, 4'd9, 7'h22, 2'd1, 4'd9, 4'd15, 7'h40, 2'd3, 4'd1,
                4'd15, 7'h40, 2'd3, 4'd1,  M_LEARN};

    reset = 1'b1;
    bus.mode_in = '0;  bus.free_keys = '0;  bus.free_note = '0;  bus.free_octave = '0;
    bus.auto_note = '0; bus.auto_led = '0;  bus.auto_octave = '0; bus.auto_num = '0;
    bus.learn_note = '0; bus.learn_led = '0; bus.learn_octave = '0; bus.learn_num = '0;

    // Reset state
    repeat (2) tick();
    check_outputs("reset", 4'd0, 7'd0, 2'd0, 4'd0, M_NONE);
    check("reset player_rst", 32'(bus.player_rst), 32'd1);
    check("reset busy",       32'(bus.busy),       32'd0);
    reset = 1'b0;
    tick();
    check("idle player_rst", 32'(bus.player_rst), 32'd0);

    // IDLE -> auto: 10-cycle latency, exactly 3 cycles of player reset
    bus.auto_note = 4'd3;
    bus.auto_num  = 4'd2;
    bus.mode_in   = M_AUTO;
    rst_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.player_rst) rst_cnt++;
      if (i == 3) check("first busy", 32'(bus.busy), 32'd1);
      if (i == 9) check("first not yet", 32'(bus.mode_active), 32'(M_NONE));
    end
    cur_mode = M_AUTO;
    check("first rst cycles", 32'(rst_cnt), 32'd3);
    check("first note",   32'(bus.note_out),    32'd3);
    check("first num",    32'(bus.num),         32'd2);
    check("first active", 32'(bus.mode_active), 32'(M_AUTO));
    check("first busy end", 32'(bus.busy), 32'd0);

    // Key override while auto is granted
    bus.auto_note = 4'd7; bus.auto_led = 7'h11; bus.auto_octave = 2'd2;
    tick();
    check("ovr pre note", 32'(bus.note_out), 32'd7);
    bus.free_keys = 7'b0000100; bus.free_note = 4'd3; bus.free_octave = 2'd1;
    tick();
`ifdef ARB_KEY_OVERRIDE_EN
    check_outputs("ovr on", 4'd3, 7'h04, 2'd1, 4'd2, M_AUTO);
`else
    check_outputs("ovr on", 4'd7, 7'h11, 2'd2, 4'd2, M_AUTO);
`endif
    check("ovr no rst", 32'(bus.player_rst), 32'd0);
    bus.free_keys = '0;
    tick();
    check_outputs("ovr off", 4'd7, 7'h11, 2'd2, 4'd2, M_AUTO);

    // Table-driven source passthrough, switching modes where needed
    for (int v = 0; v < 7; v++) begin
      bus.free_note = vecs[v].fn;  bus.free_keys = vecs[v].fk; bus.free_octave = vecs[v].fo;
      bus.auto_note = vecs[v].an;  bus.auto_led = vecs[v].al;  bus.auto_octave = vecs[v].ao;
      bus.auto_num  = vecs[v].anum;
      bus.learn_note = vecs[v].ln; bus.learn_led = vecs[v].ll; bus.learn_octave = vecs[v].lo;
      bus.learn_num  = vecs[v].lnum;
      if (vecs[v].mode != cur_mode) switch_to(vecs[v].mode);
      else tick();
      check_outputs($sformatf("vec%0d", v), vecs[v].e_note, vecs[v].e_led, vecs[v].e_oct,
                    vecs[v].e_num, vecs[v].e_act);
    end

    // Reset mid-GRANT in learn mode
    bus.learn_note = 4'd5;
    tick();
    check("pre-reset note", 32'(bus.note_out), 32'd5);
    reset = 1'b1;
    #1;
    check("async note",   32'(bus.note_out),    32'd0);
    check("async active", 32'(bus.mode_active), 32'(M_NONE));
    check("async rst",    32'(bus.player_rst),  32'd1);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) check("regrant not yet", 32'(bus.mode_active), 32'(M_NONE));
    end
    check("regrant active", 32'(bus.mode_active), 32'(M_LEARN));
    check("regrant note",   32'(bus.note_out),    32'd5);

    // Glitch in free mode: no mute, no player reset, output keeps following
    bus.free_note = 4'd6; bus.free_keys = '0;
    switch_to(M_FREE);
    check("glitch pre note", 32'(bus.note_out), 32'd6);
    rst_cnt = 0; busy_cnt = 0;
    bus.mode_in = M_LEARN;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 2) bus.mode_in = M_FREE;
      if (i == 4) bus.free_note = 4'd2;
      if (i == 5) check("glitch follow", 32'(bus.note_out), 32'd2);
      if (bus.player_rst) rst_cnt++;
      if (bus.busy) busy_cnt++;
    end
    check("glitch rst",    32'(rst_cnt),         32'd0);
    check("glitch busy",   32'(busy_cnt),        32'd2);
    check("glitch active", 32'(bus.mode_active), 32'(M_FREE));
    check("glitch note",   32'(bus.note_out),    32'd2);

    // Bouncing 010/001 every 3 cycles, then hold 001
    bus.learn_note = 4'd11; bus.learn_num = 4'd3;
    rst_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      bus.mode_in = (s == 1) ? M_LEARN : M_AUTO;
      repeat (3) begin
        tick();
        if (bus.player_rst) rst_cnt++;
      end
    end
    check("bounce held", 32'(bus.mode_active), 32'(M_FREE));
    bus.mode_in = M_LEARN;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.player_rst) rst_cnt++;
      if (i == 9) check("bounce not yet", 32'(bus.mode_active), 32'(M_NONE));
    end
    cur_mode = M_LEARN;
    check("bounce rst cycles", 32'(rst_cnt), 32'd3);
    check("bounce active",     32'(bus.mode_active), 32'(M_LEARN));
    check("bounce note",       32'(bus.note_out),    32'd11);
    check("bounce num",        32'(bus.num),         32'd3);

    // Switch to none, then an invalid code from auto
    none_check("none", M_NONE);
    switch_to(M_AUTO);
    check("reauto active", 32'(bus.mode_active), 32'(M_AUTO));
    none_check("invalid", 3'b110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
